// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 keystream XOR stage.
package rc4_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } xor_state_t;

endpackage

// File: rtl/rc4_ks_fifo.sv
// Small synchronous FIFO buffering keystream bytes; flush empties it in one cycle.
module rc4_ks_fifo
  import rc4_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [BYTE_W-1:0] din,
  output logic [BYTE_W-1:0] dout,
  output logic [CNT_W-1:0]  count
);

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/rc4_keystream_xor.sv
// Joins buffered RC4 keystream with plaintext, emitting registered ciphertext
// for exactly NUMS_OF_BYTES bytes per start.
module rc4_keystream_xor
  import rc4_pkg::*;
#(
  parameter int NUMS_OF_BYTES = 16,
  parameter int FIFO_DEPTH    = 4,
  localparam int CNT_W  = $clog2(NUMS_OF_BYTES + 1),
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              ks_valid,
  input  logic [BYTE_W-1:0] ks_data,
  output logic              ks_ready,
  input  logic              pt_valid,
  input  logic [BYTE_W-1:0] pt_data,
  output logic              pt_ready,
  output logic              ct_valid,
  output logic [BYTE_W-1:0] ct_data,
  input  logic              ct_ready,
  output logic [CNT_W-1:0]  byte_cnt,
  output logic              done
);

  localparam logic [CNT_W-1:0]  N_BYTES   = CNT_W'(NUMS_OF_BYTES);
  localparam logic [CNT_W-1:0]  N_LAST    = CNT_W'(NUMS_OF_BYTES - 1);
  localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(FIFO_DEPTH);

  xor_state_t        state_q, state_d;
  logic [CNT_W-1:0]  ks_cnt_q, ks_cnt_d;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic              ct_valid_q, ct_valid_d;
  logic [BYTE_W-1:0] ct_data_q, ct_data_d;
  logic              done_q, done_d;

  logic              flush;
  logic              ks_push;
  logic              join_fire;
  logic [BYTE_W-1:0] fifo_head;
  logic [FCNT_W-1:0] fifo_count;

  assign flush = start && ((state_q == IDLE) || (state_q == DONE));

  // Readies depend only on registered state and ct_ready, so no valid->ready path exists.
  assign ks_ready = (state_q == RUN) && (fifo_count < FIFO_FULL) && (ks_cnt_q < N_BYTES);
  assign pt_ready = (state_q == RUN) && (fifo_count != '0) && (!ct_valid_q || ct_ready);

  assign ks_push   = ks_valid && ks_ready;
  assign join_fire = pt_valid && pt_ready;

  rc4_ks_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (ks_push),
    .pop   (join_fire),
    .din   (ks_data),
    .dout  (fifo_head),
    .count (fifo_count)
  );

  always_comb begin
    state_d    = state_q;
    ks_cnt_d   = ks_cnt_q;
    byte_cnt_d = byte_cnt_q;
    ct_valid_d = ct_valid_q;
    ct_data_d  = ct_data_q;
    done_d     = done_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = RUN;
          ks_cnt_d   = '0;
          byte_cnt_d = '0;
          done_d     = 1'b0;
        end
      end
      RUN: begin
        if (ks_push) ks_cnt_d = ks_cnt_q + 1'b1;
        if (join_fire) begin
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (byte_cnt_q == N_LAST) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (ct_valid_q && ct_ready) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A new join reloads the output register even while the old byte is being taken.
    if (join_fire) begin
      ct_valid_d = 1'b1;
      ct_data_d  = pt_data ^ fifo_head;
    end else if (ct_ready) begin
      ct_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ks_cnt_q   <= '0;
      byte_cnt_q <= '0;
      ct_valid_q <= 1'b0;
      ct_data_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ks_cnt_q   <= ks_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      ct_valid_q <= ct_valid_d;
      ct_data_q  <= ct_data_d;
      done_q     <= done_d;
    end
  end

  assign ct_valid = ct_valid_q;
  assign ct_data  = ct_data_q;
  assign byte_cnt = byte_cnt_q;
  assign done     = done_q;

endmodule

// File: tb/tb_rc4_keystream_xor.sv
// Directed bench for rc4_keystream_xor: "Key" keystream over "Plaintext" with stalls, excess keystream, restarts and reset.
module tb_rc4_keystream_xor;

  localparam int NB = 9;
  localparam int NV = 12;

  typedef struct {
    logic [7:0] ks;
    logic [7:0] pt;
    logic [7:0] ct;
  } vec_t;

  vec_t vec [NV];

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       ks_valid;
  logic [7:0] ks_data;
  logic       ks_ready;
  logic       pt_valid;
  logic [7:0] pt_data;
  logic       pt_ready;
  logic       ct_valid;
  logic [7:0] ct_data;
  logic       ct_ready;
  logic [3:0] byte_cnt;
  logic       done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rc4_keystream_xor #(
    .NUMS_OF_BYTES (NB),
    .FIFO_DEPTH    (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .ks_valid (ks_valid),
    .ks_data  (ks_data),
    .ks_ready (ks_ready),
    .pt_valid (pt_valid),
    .pt_data  (pt_data),
    .pt_ready (pt_ready),
    .ct_valid (ct_valid),
    .ct_data  (ct_data),
    .ct_ready (ct_ready),
    .byte_cnt (byte_cnt),
    .done     (done)
  );

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_ks_ready"}, ks_ready, 0);
    check_output({tag, "_pt_ready"}, pt_ready, 0);
    check_output({tag, "_ct_valid"}, ct_valid, 0);
    check_output({tag, "_ct_data"},  ct_data,  0);
    check_output({tag, "_byte_cnt"}, byte_cnt, 0);
    check_output({tag, "_done"},     done,     0);
  endtask

  // Runs one message from a start pulse. stall_at<0, restart_at<0, abort_at<0 disable those features.
  task automatic apply_stimulus(input string tag, input int ks_delay, input int stall_at,
                                input int stall_len, input int ks_offer,
                                input int restart_at, input int abort_at);
    int  ks_acc = 0;
    int  pt_acc = 0;
    int  ct_acc = 0;
    int  cyc = 0;
    int  stall_left;
    int  first_ct = -1;
    int  done_cyc = -1;
    bit  in_stall;
    bit  ks_f, pt_f, ct_f;
    bit  pt_early = 0;
    bit  ks_over = 0;
    bit  seen_done = 0;
    bit  aborted = 0;
    stall_left = stall_len;

    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_output({tag, "_cnt_after_start"}, byte_cnt, 0);
    check_output({tag, "_done_after_start"}, done, 0);

    while (!seen_done && cyc < 200) begin
      if (abort_at >= 0 && pt_acc == abort_at) begin
        aborted = 1;
        break;
      end
      ks_valid = (cyc >= ks_delay) && (ks_acc < ks_offer);
      ks_data  = vec[(ks_acc < NV) ? ks_acc : 0].ks;
      pt_valid = (pt_acc < NB);
      pt_data  = vec[(pt_acc < NB) ? pt_acc : 0].pt;
      in_stall = (stall_at >= 0) && (ct_acc >= stall_at) && (stall_left > 0);
      ct_ready = !in_stall;
      start    = (cyc == restart_at);
      #1;
      if (cyc < ks_delay && pt_ready) pt_early = 1;
      if (ks_acc >= NB && ks_ready) ks_over = 1;
      if (ct_valid && first_ct < 0) first_ct = cyc;
      if (ct_acc == NB) begin
        check_output({tag, "_done_level"}, done, 1);
        check_output({tag, "_ct_valid_after_last"}, ct_valid, 0);
        seen_done = 1;
        done_cyc  = cyc;
      end else if (ct_valid) begin
        check_output($sformatf("%s_ct%0d", tag, ct_acc), ct_data, vec[ct_acc].ct);
        if (ct_ready && ct_acc == NB - 1) check_output({tag, "_done_before_last"}, done, 0);
      end
      if (in_stall) begin
        if (stall_left == 1) begin
          check_output({tag, "_fifo_fill"}, ks_acc - pt_acc, 4);
          check_output({tag, "_ks_ready_full"}, ks_ready, 0);
        end
        stall_left--;
      end
      ks_f = ks_valid && ks_ready;
      pt_f = pt_valid && pt_ready;
      ct_f = ct_valid && ct_ready;
      @(posedge clk);
      if (ks_f) ks_acc++;
      if (pt_f) pt_acc++;
      if (ct_f) ct_acc++;
      @(negedge clk);
      cyc++;
    end

    ks_valid = 1'b0;
    pt_valid = 1'b0;
    start    = 1'b0;
    ct_ready = 1'b1;
    if (aborted) return;

    check_output({tag, "_done_seen"}, seen_done, 1);
    check_output({tag, "_ct_count"}, ct_acc, NB);
    check_output({tag, "_ks_accepted"}, ks_acc, NB);
    check_output({tag, "_byte_cnt"}, byte_cnt, NB);
    check_output({tag, "_first_ct_cycle"}, first_ct, ks_delay + 2);
    if (ks_delay > 0) check_output({tag, "_pt_ready_early"}, pt_early, 0);
    if (ks_offer > NB) check_output({tag, "_ks_ready_after_last"}, ks_over, 0);
    if (stall_len == 0) check_output({tag, "_done_cycle"}, done_cyc, ks_delay + NB + 2);
    repeat (3) @(negedge clk);
    #1;
    check_output({tag, "_done_hold"}, done, 1);
    check_output({tag, "_ks_ready_done"}, ks_ready, 0);
  endtask

  initial begin
    vec[0]  = '{8'hEB, 8'h50, 8'hBB};
    vec[1]  = '{8'h9F, 8'h6C, 8'hF3};
    vec[2]  = '{8'h77, 8'h61, 8'h16};
    vec[3]  = '{8'h81, 8'h69, 8'hE8};
    vec[4]  = '{8'hB7, 8'h6E, 8'hD9};
    vec[5]  = '{8'h34, 8'h74, 8'h40};
    vec[6]  = '{8'hCA, 8'h65, 8'hAF};
    vec[7]  = '{8'h72, 8'h78, 8'h0A};
    vec[8]  = '{8'hA7, 8'h74, 8'hD3};
    vec[9]  = '{8'h11, 8'h00, 8'h11};
    vec[10] = '{8'h22, 8'h00, 8'h22};
    vec[11] = '{8'h33, 8'h00, 8'h33};

    rst_n    = 1'b0;
    start    = 1'b0;
    ks_valid = 1'b0;
    ks_data  = 8'h00;
    pt_valid = 1'b0;
    pt_data  = 8'h00;
    ct_ready = 1'b1;
    #3;
    check_reset_values("por");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check_reset_values("idle");

    apply_stimulus("basic",    0, -1, 0, NB, -1, -1);
    apply_stimulus("ks_late",  5, -1, 0, NB, -1, -1);
    apply_stimulus("ct_stall", 0,  2, 6, NB, -1, -1);
    apply_stimulus("ks_extra", 0, -1, 0, 12, -1, -1);
    apply_stimulus("restart",  0, -1, 0, NB,  4, -1);
    apply_stimulus("abort",    0, -1, 0, NB, -1,  4);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus("after_rst", 0, -1, 0, NB, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
